filterbank_dbuf_ccf: RTL and testbench

//  Polyphase complex filterbank, successor to the single-bank design. Round-robins
//  N channels, one complex sample per in_nd, and outputs one FIR output per input.

---
 rtl/filterbank_pkg.sv | 40 ++++
 rtl/filterbank_cdot.sv | 86 ++++++++
 rtl/filterbank_dbuf_ccf.sv | 192 +++++++++++++++++++
 tb/tb_filterbank_dbuf_ccf.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filterbank_pkg.sv
// Shared constants, FSM state type and the output saturation helper for the filterbank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package filterbank_pkg;

  // Default complex sample width; each real/imag half is TAP_W bits
  localparam int WDTH_DFLT   = 32;
  localparam int TAP_W       = WDTH_DFLT / 2;
  localparam int MSG_WIDTH   = WDTH_DFLT + 1;
  localparam int MSG_HDR_BIT = MSG_WIDTH - 1;
  // Taps are Q1.(TAP_W-1): this many fractional bits are dropped after accumulation
  localparam int TAP_FRAC    = TAP_W - 1;

  typedef enum logic {
    LD_IDLE    = 1'b0,
    LD_LOADING = 1'b1
  } ld_state_t;

  typedef struct packed {
    logic             ovf;
    logic [TAP_W-1:0] val;
  } sat_t;

  // Clamp a scaled accumulator to a signed TAP_W-bit result, flagging any clipping
  function automatic sat_t sat(input logic signed [63:0] v);
    sat_t r;
    if (v > ((64'sd1 <<< TAP_FRAC) - 64'sd1)) begin
      r.ovf = 1'b1;
      r.val = {1'b0, {(TAP_W-1){1'b1}}};
    end else if (v < -(64'sd1 <<< TAP_FRAC)) begin
      r.ovf = 1'b1;
      r.val = {1'b1, {(TAP_W-1){1'b0}}};
    end else begin
      r.ovf = 1'b0;
      r.val = v[TAP_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/filterbank_cdot.sv
// Pipelined complex-by-real dot product of FLTLEN terms with saturation flag and sideband pipe.
// Latency: 2 cycles (S2 multiply, S3 sum/scale/saturate).
// Backpressure: none; accepts one window per cycle when vld is high.
module filterbank_cdot
  import filterbank_pkg::*;
#(
  parameter int WDTH       = 32,
  parameter int FLTLEN     = 3,
  parameter int LOG_FLTLEN = 2,
  parameter int SB_W       = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vld,
  input  logic [FLTLEN-1:0][WDTH-1:0]      win,
  input  logic [FLTLEN-1:0][WDTH/2-1:0]    taps,
  input  logic [SB_W-1:0]                  sb,
  output logic                             res_vld,
  output logic [WDTH-1:0]                  res_dat,
  output logic [SB_W-1:0]                  res_sb,
  output logic                             res_sat
);

  localparam int HALF  = WDTH / 2;
  localparam int ACC_W = WDTH + LOG_FLTLEN;

  logic                    s2_vld;
  logic [SB_W-1:0]         s2_sb;
  logic signed [WDTH-1:0]  prod_re [FLTLEN];
  logic signed [WDTH-1:0]  prod_im [FLTLEN];
  logic signed [ACC_W-1:0] acc_re, acc_im, scl_re, scl_im;
  sat_t                    sat_re, sat_im;

  // S2: per-tap products, full precision, real and imag against the same real tap
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_sb  <= '0;
      for (int k = 0; k < FLTLEN; k++) begin
        prod_re[k] <= '0;
        prod_im[k] <= '0;
      end
    end else begin
      s2_vld <= vld;
      if (vld) begin
        s2_sb <= sb;
        for (int k = 0; k < FLTLEN; k++) begin
          prod_re[k] <= WDTH'($signed(win[k][WDTH-1:HALF])) * WDTH'($signed(taps[k]));
          prod_im[k] <= WDTH'($signed(win[k][HALF-1:0]))    * WDTH'($signed(taps[k]));
        end
      end
    end
  end

  // S3 combinational part: sum, drop the tap fraction bits, saturate
  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int k = 0; k < FLTLEN; k++) begin
      acc_re = acc_re + ACC_W'(prod_re[k]);
      acc_im = acc_im + ACC_W'(prod_im[k]);
    end
    scl_re = acc_re >>> (HALF - 1);
    scl_im = acc_im >>> (HALF - 1);
    sat_re = sat(64'(scl_re));
    sat_im = sat(64'(scl_im));
  end

  // S3 register: result, sideband and saturation flag leave together
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_dat <= '0;
      res_sb  <= '0;
      res_sat <= 1'b0;
    end else begin
      res_vld <= s2_vld;
      if (s2_vld) begin
        res_dat <= {sat_re.val, sat_im.val};
        res_sb  <= s2_sb;
        res_sat <= sat_re.ovf | sat_im.ovf;
      end
    end
  end

endmodule

// File: rtl/filterbank_dbuf_ccf.sv
// Polyphase complex filterbank, N round-robin channels, double-buffered taps swapped at frame start.
// Latency: 3 cycles in_nd -> out_nd (S1 window/taps, S2 multiply, S3 sum/saturate).
// Backpressure: none; one sample per in_nd, one tap word per in_msg_nd.
module filterbank_dbuf_ccf
  import filterbank_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOG_N      = 2,
  parameter int WDTH       = 32,
  parameter int MWDTH      = 1,
  parameter int FLTLEN     = 3,
  parameter int LOG_FLTLEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  input  logic [MWDTH-1:0]     in_m,
  input  logic [MSG_WIDTH-1:0] in_msg,
  input  logic                 in_msg_nd,
  output logic [WDTH-1:0]      out_data,
  output logic                 out_nd,
  output logic [MWDTH-1:0]     out_m,
  output logic [LOG_N-1:0]     out_chan,
  output logic                 first_filter,
  output logic                 error
);

  localparam int HALF = WDTH / 2;

  typedef struct packed {
    logic [MWDTH-1:0] m;
    logic [LOG_N-1:0] chan;
  } meta_t;

  logic [LOG_N-1:0]           chan;
  logic [WDTH-1:0]            hist [N][FLTLEN-1];
  logic [HALF-1:0]            bank [2][N][FLTLEN];
  logic                       active, shadow, pending;
  ld_state_t                  ld_state, ld_state_nx;
  logic [LOG_N-1:0]           ld_filt, ld_filt_nx;
  logic [LOG_FLTLEN-1:0]      ld_pos, ld_pos_nx;
  logic                       tap_we, load_done, hdr_err;
  logic                       do_swap, sel;
  logic                       s1_vld;
  logic [FLTLEN-1:0][WDTH-1:0] s1_win;
  logic [FLTLEN-1:0][HALF-1:0] s1_tap;
  meta_t                      s1_meta, res_meta;
  logic                       res_vld, res_sat;
  logic [WDTH-1:0]            res_dat;
  logic                       unused_msg_bits;

  // Only the header bit and the low tap bits of a message word carry information
  assign unused_msg_bits = ^in_msg[WDTH-1:HALF];

  assign shadow  = ~active;
  // A pending bank swaps in on the first channel-0 sample once loading has finished
  assign do_swap = in_nd && (chan == '0) && pending && (ld_state == LD_IDLE);
  assign sel     = active ^ do_swap;

  // Channel counter, advanced only by accepted samples
  always_ff @(posedge clk) begin
    if (rst)        chan <= '0;
    else if (in_nd) chan <= (chan == LOG_N'(N - 1)) ? '0 : chan + 1'b1;
  end

  // Per-channel sample history, newest in slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++)
        for (int k = 0; k < FLTLEN - 1; k++)
          hist[c][k] <= '0;
    end else if (in_nd) begin
      hist[chan][0] <= in_data;
      for (int k = 1; k < FLTLEN - 1; k++)
        hist[chan][k] <= hist[chan][k-1];
    end
  end

  // Tap banks; loads only ever write the bank not in use
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < N; c++)
          for (int k = 0; k < FLTLEN; k++)
            bank[b][c][k] <= '0;
    end else if (tap_we) begin
      bank[shadow][ld_filt][ld_pos] <= in_msg[HALF-1:0];
    end
  end

  // Load FSM next state: headers (re)start at filter 0, data words step pos then filter
  always_comb begin
    ld_state_nx = ld_state;
    ld_filt_nx  = ld_filt;
    ld_pos_nx   = ld_pos;
    tap_we      = 1'b0;
    load_done   = 1'b0;
    hdr_err     = 1'b0;
    if (in_msg_nd) begin
      if (in_msg[MSG_HDR_BIT]) begin
        hdr_err     = (ld_state == LD_LOADING);
        ld_state_nx = LD_LOADING;
        ld_filt_nx  = '0;
        ld_pos_nx   = '0;
      end else if (ld_state == LD_LOADING) begin
        tap_we = 1'b1;
        if (ld_pos == LOG_FLTLEN'(FLTLEN - 1)) begin
          ld_pos_nx = '0;
          if (ld_filt == LOG_N'(N - 1)) begin
            ld_state_nx = LD_IDLE;
            ld_filt_nx  = '0;
            load_done   = 1'b1;
          end else begin
            ld_filt_nx = ld_filt + 1'b1;
          end
        end else begin
          ld_pos_nx = ld_pos + 1'b1;
        end
      end
    end
  end

  // Load FSM registers, pending-swap flag and active bank select
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state <= LD_IDLE;
      ld_filt  <= '0;
      ld_pos   <= '0;
      pending  <= 1'b0;
      active   <= 1'b0;
    end else begin
      ld_state <= ld_state_nx;
      ld_filt  <= ld_filt_nx;
      ld_pos   <= ld_pos_nx;
      if (load_done)    pending <= 1'b1;
      else if (do_swap) pending <= 1'b0;
      if (do_swap) active <= ~active;
    end
  end

  // S1: capture the sample window and this channel's taps (post-swap bank)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_win  <= '0;
      s1_tap  <= '0;
      s1_meta <= '0;
    end else begin
      s1_vld <= in_nd;
      if (in_nd) begin
        s1_win[0] <= in_data;
        for (int k = 1; k < FLTLEN; k++)
          s1_win[k] <= hist[chan][k-1];
        for (int k = 0; k < FLTLEN; k++)
          s1_tap[k] <= bank[sel][chan][k];
        s1_meta <= '{m: in_m, chan: chan};
      end
    end
  end

  filterbank_cdot #(
    .WDTH       (WDTH),
    .FLTLEN     (FLTLEN),
    .LOG_FLTLEN (LOG_FLTLEN),
    .SB_W       ($bits(meta_t))
  ) u_cdot (
    .clk     (clk),
    .rst     (rst),
    .vld     (s1_vld),
    .win     (s1_win),
    .taps    (s1_tap),
    .sb      (s1_meta),
    .res_vld (res_vld),
    .res_dat (res_dat),
    .res_sb  (res_meta),
    .res_sat (res_sat)
  );

  // Sticky error: header during a load, or any saturated output
  always_ff @(posedge clk) begin
    if (rst)                                  error <= 1'b0;
    else if (hdr_err || (res_vld && res_sat)) error <= 1'b1;
  end

  assign out_data     = res_dat;
  assign out_nd       = res_vld;
  assign out_m        = res_meta.m;
  assign out_chan     = res_meta.chan;
  assign first_filter = res_vld && (res_meta.chan == '0);

endmodule

// File: tb/tb_filterbank_dbuf_ccf.sv
// Self-checking bench: reference model pushes expected outputs to a scoreboard, monitor pops.
// Latency: expects every output exactly 3 cycles after its in_nd.
// Backpressure: none exercised; the design has none.
module tb_filterbank_dbuf_ccf;
  import filterbank_pkg::*;

  localparam logic [MSG_WIDTH-1:0] HDR = 33'h1_0000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          in_data;
  logic                 in_nd;
  logic [0:0]           in_m;
  logic [MSG_WIDTH-1:0] in_msg;
  logic                 in_msg_nd;
  logic [31:0]          out_data;
  logic                 out_nd;
  logic [0:0]           out_m;
  logic [1:0]           out_chan;
  logic                 first_filter;
  logic                 error;

  filterbank_dbuf_ccf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd), .out_data(out_data), .out_nd(out_nd),
    .out_m(out_m), .out_chan(out_chan), .first_filter(first_filter), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    int          chan;
    logic        m;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Reference model state
  logic [15:0] mtap [2][4][3];
  logic [31:0] mhist [4][2];
  int          mact, mchan, mfilt, mpos;
  bit          mpend, mload, merr;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mk(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [15:0] sat16(input longint v, inout bit ovf);
    if (v > 32767)       begin ovf = 1'b1; return 16'h7fff; end
    else if (v < -32768) begin ovf = 1'b1; return 16'h8000; end
    return 16'(v);
  endfunction

  function automatic logic [31:0] fir(input int c, input logic [31:0] x, output bit ovf);
    longint ar, ai, t;
    logic [31:0] s;
    logic [15:0] yr, yi;
    ar = 0; ai = 0; ovf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s  = (k == 0) ? x : mhist[c][k-1];
      t  = longint'($signed(mtap[mact][c][k]));
      ar = ar + longint'($signed(s[31:16])) * t;
      ai = ai + longint'($signed(s[15:0])) * t;
    end
    yr = sat16(ar >>> 15, ovf);
    yi = sat16(ai >>> 15, ovf);
    return {yr, yi};
  endfunction

  function automatic logic [15:0] tapv(input int kind, input int f, input int p);
    case (kind)
      0:       return (p == 0) ? 16'd16384 : 16'd0;
      1:       return (p == 0) ? 16'(4096 * (f + 1)) : (p == 1) ? 16'hf800 : 16'd1024;
      2:       return 16'd32767;
      3:       return (p == 0) ? 16'd16384 : (p == 1) ? 16'd8192 : 16'd4096;
      default: return (p == 2) ? 16'he000 : 16'd8192;
    endcase
  endfunction

  task automatic mreset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 3; k++) mtap[b][c][k] = '0;
    for (int c = 0; c < 4; c++) begin mhist[c][0] = '0; mhist[c][1] = '0; end
    mact = 0; mchan = 0; mfilt = 0; mpos = 0; mpend = 0; mload = 0; merr = 0;
  endtask

  // One cycle of stimulus; the model sees it as the DUT will at the next edge
  task automatic drive(input bit nd, input logic [31:0] d, input logic mm,
                       input bit mnd, input logic [MSG_WIDTH-1:0] msg);
    exp_t e;
    bit   ovf;
    in_nd = nd; in_data = d; in_m = mm; in_msg_nd = mnd; in_msg = msg;
    if (nd) begin
      if (mchan == 0 && mpend && !mload) begin mact ^= 1; mpend = 0; end
      e.dat  = fir(mchan, d, ovf);
      e.chan = mchan; e.m = mm; e.cyc = cyc + 3;
      if (ovf) merr = 1;
      sbq.push_back(e);
      mhist[mchan][1] = mhist[mchan][0];
      mhist[mchan][0] = d;
      mchan = (mchan + 1) % 4;
    end
    if (mnd) begin
      if (msg[MSG_HDR_BIT]) begin
        if (mload) merr = 1;
        mload = 1; mfilt = 0; mpos = 0;
      end else if (mload) begin
        mtap[mact ^ 1][mfilt][mpos] = msg[15:0];
        if (mpos == 2) begin
          mpos = 0;
          if (mfilt == 3) begin mload = 0; mpend = 1; mfilt = 0; end
          else mfilt++;
        end else mpos++;
      end
    end
    @(posedge clk); #1;
    in_nd = 1'b0; in_msg_nd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, 1'b0, 0, '0);
  endtask

  task automatic sample(input logic [31:0] d);
    drive(1, d, 1'($urandom_range(0, 1)), 0, '0);
  endtask

  function automatic logic [31:0] rnd();
    return mk(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
  endfunction

  task automatic word(input logic [15:0] t);
    drive(0, '0, 1'b0, 1, {17'b0, t});
  endtask

  // Header plus N*FLTLEN taps; optionally a sample rides in the cycle of the last word
  task automatic load_fn(input int kind, input bit last_nd, input logic [31:0] d);
    drive(0, '0, 1'b0, 1, HDR);
    for (int i = 0; i < 12; i++) begin
      if (i == 11 && last_nd)
        drive(1, d, 1'b1, 1, {17'b0, tapv(kind, i / 3, i % 3)});
      else
        word(tapv(kind, i / 3, i % 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    mreset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_nd"}, out_nd, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_m"}, out_m, 0);
    chk({tag, "_out_chan"}, out_chan, 0);
    chk({tag, "_first_filter"}, first_filter, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Scoreboard: each output must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    if (out_nd === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_data", out_data, e.dat);
        chk("out_chan", out_chan, e.chan);
        chk("out_m", out_m, e.m);
        chk("first_filter", first_filter, e.chan == 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_nd = 1'b0; in_m = '0; in_msg = '0; in_msg_nd = 1'b0;
    mreset();
    @(posedge clk); #1;
    do_reset();
    chk_reset_state("reset");

    // 1: zero taps, two frames with gaps -> all zero outputs
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) begin
        sample(mk(1000, -1000));
        if (c == 1) idle(2);
      end
    idle(5);

    // 2: pos0 taps 0.5 -> 500/-500 after swap at frame start
    load_fn(0, 0, '0);
    idle(2);
    repeat (8) sample(mk(1000, -1000));
    idle(5);

    // 3: load completes alongside ch2 sample; then alongside a ch0 sample
    sample(rnd()); sample(rnd());
    load_fn(1, 1, rnd());
    repeat (5) sample(rnd());
    idle(2);
    while (mchan != 0) sample(rnd());
    load_fn(3, 1, rnd());
    repeat (8) sample(rnd());
    idle(5);

    // 4: header mid-load sets sticky error; restarted load still completes and swaps
    drive(0, '0, 1'b0, 1, HDR);
    for (int i = 0; i < 5; i++) word(tapv(4, i / 3, i % 3));
    load_fn(4, 0, '0);
    idle(4);
    chk("err_after_hdr", error, merr);
    while (mchan != 0) sample(rnd());
    repeat (8) sample(rnd());
    idle(5);
    chk("err_sticky", error, 1);

    // 5: full-scale taps and input -> saturation sets error
    do_reset();
    chk_reset_state("reset2");
    load_fn(2, 0, '0);
    repeat (4) sample(mk(32767, 32767));
    idle(5);
    chk("err_before_sat", error, merr);
    repeat (8) sample(mk(32767, 32767));
    idle(5);
    chk("err_after_sat", error, merr);

    // 6: reset mid-stream and mid-load; then stray data words are ignored
    do_reset();
    load_fn(3, 0, '0);
    repeat (6) sample(rnd());
    drive(0, '0, 1'b0, 1, HDR);
    drive(1, rnd(), 1'b1, 1, {17'b0, 16'd1234});
    drive(1, rnd(), 1'b0, 1, {17'b0, 16'd2345});
    sample(rnd());
    do_reset();
    chk_reset_state("reset_mid");
    for (int i = 0; i < 12; i++) word(16'd20000);
    repeat (8) sample(rnd());
    idle(6);
    chk("err_final", error, merr);
    chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
